// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control inputs from hazard/EX units, instruction memory read, IF/ID outputs.
// Latency: none, this is a signal bundle only.
// Backpressure: stall travels on this bundle; fetch_stage holds everything while it is high.
interface fetch_stage_if #(
    parameter int PC_W   = 5,
    parameter int INST_W = 8
);
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [INST_W-1:0] inst_in;
    logic [PC_W-1:0]   pc_out;
    logic [INST_W-1:0] ifid_inst;
    logic [PC_W-1:0]   ifid_pc;
    logic              ifid_valid;
    logic              halted;

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, inst_in,
        output pc_out, ifid_inst, ifid_pc, ifid_valid, halted
    );

    // Pipeline / memory side
    modport slave (
        output stall, redirect, redirect_pc, inst_in,
        input  pc_out, ifid_inst, ifid_pc, ifid_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads instruction memory combinationally, fills the IF/ID register (BOOT/RUN/HALTED FSM).
// Latency: 1 cycle from pc_out=A to the instruction at A in ifid_inst; one instruction per cycle in RUN.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall. Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_stage #(
    parameter int                PC_W      = 5,
    parameter int                INST_W    = 8,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [INST_W-1:0] NOP_INST  = 8'h00,
    parameter logic [INST_W-1:0] HALT_INST = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_count,
    output logic [15:0]        stall_count
`endif
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ifid_t;

    localparam ifid_t BUBBLE = '{valid: 1'b0, pc: '0, inst: NOP_INST};

    state_t          state;
    logic [PC_W-1:0] pc;
    ifid_t           ifid;
    logic            halted_q;

    // PC goes straight to memory; no input reaches pc_out combinationally
    assign bus.pc_out     = pc;
    assign bus.ifid_inst  = ifid.inst;
    assign bus.ifid_pc    = ifid.pc;
    assign bus.ifid_valid = ifid.valid;
    assign bus.halted     = halted_q;

    // Fetch FSM: PC, IF/ID register and halted flag update together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            ifid     <= BUBBLE;
            halted_q <= 1'b0;
        end else begin
            case (state)
                // Memory is not settled yet: burn one edge, ignore redirect/stall
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.redirect) begin
                        pc   <= bus.redirect_pc;
                        ifid <= BUBBLE;
                    end else if (!bus.stall) begin
                        ifid <= '{valid: 1'b1, pc: pc, inst: bus.inst_in};
                        if (bus.inst_in == HALT_INST) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                HALTED: begin
                    if (bus.redirect) begin
                        pc       <= bus.redirect_pc;
                        ifid     <= BUBBLE;
                        state    <= RUN;
                        halted_q <= 1'b0;
                    end else if (!bus.stall) begin
                        // stall keeps the halt instruction in IF/ID until decode takes it
                        ifid <= BUBBLE;
                    end
                end
                default: begin
                    state    <= BOOT;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic stall_evt;

    assign fetch_evt = (state == RUN) && !bus.redirect && !bus.stall;
    assign stall_evt = (state == RUN) && bus.stall && !bus.redirect;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (fetch_evt && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
            if (stall_evt && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a driver issues one vector per cycle and queues the expected state after that edge.
// A monitor pops and compares shortly after each rising edge; async reset is checked directly mid-cycle.
// Memory is a table in the bench, read combinationally at pc_out.
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if #(.PC_W(5), .INST_W(8)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    logic [7:0] mem [32];
    assign bus.inst_in = mem[bus.pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [4:0] pc;
        logic [7:0] inst;
        logic [4:0] ipc;
        logic       v;
        logic       h;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the expected state after the next edge
    task automatic step(input logic s, input logic r, input logic [4:0] rpc,
                        input logic [4:0] epc, input logic [7:0] einst,
                        input logic [4:0] eipc, input logic ev, input logic eh);
        exp_t e;
        @(negedge clk);
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        step_id++;
        e.id = step_id; e.pc = epc; e.inst = einst; e.ipc = eipc; e.v = ev; e.h = eh;
        exp_q.push_back(e);
    endtask

    // Monitor: compare after every edge that has a queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("step%0d pc_out", e.id), 32'(bus.pc_out), 32'(e.pc));
                chk($sformatf("step%0d ifid_inst", e.id), 32'(bus.ifid_inst), 32'(e.inst));
                if (!$isunknown(e.ipc))
                    chk($sformatf("step%0d ifid_pc", e.id), 32'(bus.ifid_pc), 32'(e.ipc));
                chk($sformatf("step%0d ifid_valid", e.id), 32'(bus.ifid_valid), 32'(e.v));
                chk($sformatf("step%0d halted", e.id), 32'(bus.halted), 32'(e.h));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc_out"}, 32'(bus.pc_out), 32'd0);
        chk({tag, " ifid_inst"}, 32'(bus.ifid_inst), 32'h00);
        chk({tag, " ifid_pc"}, 32'(bus.ifid_pc), 32'd0);
        chk({tag, " ifid_valid"}, 32'(bus.ifid_valid), 32'd0);
        chk({tag, " halted"}, 32'(bus.halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, " fetch_count"}, 32'(fetch_count), 32'd0);
        chk({tag, " stall_count"}, 32'(stall_count), 32'd0);
`endif
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(8'h20 + i);
        mem[0] = 8'h00; mem[1] = 8'h0B; mem[2] = 8'h49; mem[3] = 8'h12;
        mem[6] = 8'hFF;

        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        #12;
        chk_reset_state("reset");

        @(posedge clk); #2; rst = 1'b1;

        // BOOT edge: stall and redirect ignored
        step(1, 1, 5'd9, 5'd0, 8'h00, 5'd0, 0, 0);
        step(0, 0, 5'd0, 5'd1, 8'h00, 5'd0, 1, 0);
        step(0, 0, 5'd0, 5'd2, 8'h0B, 5'd1, 1, 0);
        step(0, 0, 5'd0, 5'd3, 8'h49, 5'd2, 1, 0);
        // stall two edges at pc=3
        step(1, 0, 5'd0, 5'd3, 8'h49, 5'd2, 1, 0);
        step(1, 0, 5'd0, 5'd3, 8'h49, 5'd2, 1, 0);
        step(0, 0, 5'd0, 5'd4, 8'h12, 5'd3, 1, 0);
        // redirect beats stall
        step(1, 1, 5'd20, 5'd20, 8'h00, 5'd0, 0, 0);
        step(0, 0, 5'd0, 5'd21, 8'h34, 5'd20, 1, 0);
        // run to 31 and wrap
        for (int a = 21; a <= 31; a++)
            step(0, 0, 5'd0, 5'(a + 1), mem[a], 5'(a), 1, 0);
        step(0, 0, 5'd0, 5'd1, 8'h00, 5'd0, 1, 0);
        step(0, 0, 5'd0, 5'd2, 8'h0B, 5'd1, 1, 0);
        step(0, 0, 5'd0, 5'd3, 8'h49, 5'd2, 1, 0);
        step(0, 0, 5'd0, 5'd4, 8'h12, 5'd3, 1, 0);
        step(0, 0, 5'd0, 5'd5, 8'h24, 5'd4, 1, 0);
        step(0, 0, 5'd0, 5'd6, 8'h25, 5'd5, 1, 0);
        // halt at 6
        step(0, 0, 5'd0, 5'd6, 8'hFF, 5'd6, 1, 1);
        // stall while halted drains nothing: FF stays in IF/ID
        step(1, 0, 5'd0, 5'd6, 8'hFF, 5'd6, 1, 1);
        step(0, 0, 5'd0, 5'd6, 8'h00, 5'bx, 0, 1);
        step(0, 0, 5'd0, 5'd6, 8'h00, 5'bx, 0, 1);
        step(0, 0, 5'd0, 5'd6, 8'h00, 5'bx, 0, 1);
        // leave HALTED by redirect
        step(0, 1, 5'd1, 5'd1, 8'h00, 5'd0, 0, 0);
        step(0, 0, 5'd0, 5'd2, 8'h0B, 5'd1, 1, 0);
        // skip past the halt opcode
        step(0, 1, 5'd8, 5'd8, 8'h00, 5'd0, 0, 0);
        step(0, 0, 5'd0, 5'd9, 8'h28, 5'd8, 1, 0);
        step(0, 0, 5'd0, 5'd10, 8'h29, 5'd9, 1, 0);
        step(0, 0, 5'd0, 5'd11, 8'h2A, 5'd10, 1, 0);
        step(0, 0, 5'd0, 5'd12, 8'h2B, 5'd11, 1, 0);

        // async reset mid-cycle at pc=12
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk); #1;
        chk_reset_state("reset_held");
        #1; rst = 1'b1;

        step(0, 0, 5'd0, 5'd0, 8'h00, 5'd0, 0, 0);
        step(0, 0, 5'd0, 5'd1, 8'h00, 5'd0, 1, 0);
        step(0, 0, 5'd0, 5'd2, 8'h0B, 5'd1, 1, 0);

        @(posedge clk); #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 8-bit pipelined MIPS-style core. Owns the program counter, drives the 5-bit address into the instruction memory, and captures the returned 8-bit instruction into the IF/ID pipeline register for decode.
- Handles stall (load-use hazard), redirect (taken branch/jump from EX), and a halt instruction.

Parameters:
- PC_W, 5, program-counter width; instruction memory depth is 2^PC_W.
- INST_W, 8, instruction width.
- RESET_PC, 5'd0, PC value loaded at reset.
- NOP_INST, 8'h00, bubble inserted into IF/ID on flush or while halted.
- HALT_INST, 8'hFF, opcode that stops fetching.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; rst=0 resets the block immediately, independent of clk.
- stall  input  1  from hazard unit; hold PC and IF/ID.
- redirect  input  1  from EX; taken branch/jump this cycle.
- redirect_pc  input  PC_W  target address when redirect=1.
- inst_in  input  INST_W  instruction returned by the instruction memory for pc_out (combinational read, same cycle).
- pc_out  output  PC_W  current fetch address to the instruction memory.
- ifid_inst  output  INST_W  IF/ID instruction register.
- ifid_pc  output  PC_W  IF/ID copy of the fetch address of ifid_inst.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  FSM is in HALTED.

Behaviour:
- Reset values (rst=0): pc=RESET_PC, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, state=BOOT, halted=0.
- pc_out is the PC register output directly (no combinational path from the inputs).
- FSM states: BOOT, RUN, HALTED.
- BOOT: lasts one clk edge after reset deassertion. No fetch, PC holds, IF/ID holds bubble. The instruction memory contents are settled after this edge. Transition is always BOOT -> RUN; redirect and stall are ignored in BOOT.
- RUN, per rising edge, priority highest first:
  1. redirect=1: pc<=redirect_pc, ifid_inst<=NOP_INST, ifid_valid<=0, ifid_pc<=0. Redirect overrides stall.
  2. stall=1: pc, ifid_inst, ifid_pc and ifid_valid all hold.
  3. inst_in==HALT_INST: ifid_inst<=inst_in, ifid_pc<=pc, ifid_valid<=1, pc holds, state->HALTED.
  4. Otherwise: ifid_inst<=inst_in, ifid_pc<=pc, ifid_valid<=1, pc<=pc+1 modulo 2^PC_W (31 wraps to 0).
- HALTED: halted=1 and pc holds. Each edge loads a bubble (NOP_INST, valid=0) unless stall=1, in which case IF/ID holds so the halt instruction can drain. redirect=1 sets pc<=redirect_pc, loads a bubble and moves to RUN. Only redirect or reset leaves HALTED.
- Latency: an instruction at address A appears in ifid_inst on the edge that ends the cycle where pc_out=A, i.e. 1 cycle.
- Reset mid-operation: all state returns to reset values asynchronously; no partial update survives. The FSM re-enters BOOT.
- Throughput: one instruction per cycle in RUN with no stall or redirect.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds two 16-bit outputs, fetch_count and stall_count, both reset to 0.
  - fetch_count increments on every edge that loads ifid_valid<=1.
  - stall_count increments on every RUN edge with stall=1 and redirect=0.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Reset, then run 4 edges with memory bytes {00,0B,49,12,...} -> BOOT edge leaves pc=0, then ifid_inst=00/0B/49 with ifid_pc=0/1/2, ifid_valid=1, pc_out=3.
- Hold stall=1 for 2 edges at pc=3 -> pc_out stays 3 and IF/ID is unchanged; after release, ifid_inst=mem[3], ifid_pc=3.
- Assert stall=1 and redirect=1 with redirect_pc=20 together -> pc_out=20, ifid_valid=0, ifid_inst=00; next edge ifid_inst=mem[20], ifid_pc=20.
- Run through pc=31 with no redirect -> ifid_pc=31, then pc_out=0 (wrap-around).
- Place FF at address 6 -> ifid_inst=FF with ifid_valid=1, then halted=1 with pc_out stuck at 6 and bubbles for 3 edges; redirect_pc=1 -> halted=0, pc_out=1.
- Pull rst low asynchronously mid-cycle at pc=12 -> outputs return to reset values before the next clk edge; after release, one BOOT edge, then fetch resumes from 0. With FETCH_PERF_CNT_EN defined, both counters read 0.
